// File: rtl/rps_pkg.sv
// Shared types for the rock-paper-scissors match controller: one-hot move codes,
// round result and winner encodings, and the controller state type.
package rps_pkg;

  localparam logic [2:0] ROCK     = 3'b001;
  localparam logic [2:0] PAPER    = 3'b010;
  localparam logic [2:0] SCISSORS = 3'b100;

  typedef enum logic [1:0] {
    NONE  = 2'b00,
    A_WIN = 2'b01,
    B_WIN = 2'b10,
    TIE   = 2'b11
  } result_e;

  typedef enum logic [1:0] {
    WIN_NONE = 2'b00,
    WIN_A    = 2'b01,
    WIN_B    = 2'b10,
    WIN_DRAW = 2'b11
  } winner_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EVAL = 2'b01,
    DONE = 2'b10
  } state_e;

endpackage

// File: rtl/rps_judge.sv
// Combinational round judge: compares two one-hot moves and reports the outcome.
// Non-one-hot pairs that are not equal yield NONE.
module rps_judge
  import rps_pkg::*;
(
  input  logic [2:0] move_a,
  input  logic [2:0] move_b,
  output result_e    result
);

  // NOTE: every output of a combinational block gets a default first so no
  // path through the if/else chain leaves it unassigned and infers a latch.
  always_comb begin
    result = NONE;
    if (move_a == move_b) begin
      result = TIE;
    end else if ((move_a == ROCK     && move_b == SCISSORS) ||
                 (move_a == SCISSORS && move_b == PAPER)    ||
                 (move_a == PAPER    && move_b == ROCK)) begin
      result = A_WIN;
    end else if ((move_b == ROCK     && move_a == SCISSORS) ||
                 (move_b == SCISSORS && move_a == PAPER)    ||
                 (move_b == PAPER    && move_a == ROCK)) begin
      result = B_WIN;
    end
  end

endmodule

// File: rtl/rps_match_ctrl.sv
// Match controller: latches submitted moves, judges a round one cycle later,
// keeps scores and declares the winner. Define RPS_TIE_LIMIT_EN to end a match as
// a draw after TIE_LIMIT consecutive ties.
module rps_match_ctrl
  import rps_pkg::*;
#(
  parameter  int WIN_ROUNDS = 3,
  parameter  int TIE_LIMIT  = 5,
  localparam int SCORE_W    = $clog2(WIN_ROUNDS + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [2:0]         move_a,
  input  logic [2:0]         move_b,
  input  logic               move_valid,
  input  logic               submit,
  input  logic               new_match,
  output logic               invalid_pulse,
  output logic               result_valid,
  output logic [1:0]         round_result,
  output logic [SCORE_W-1:0] score_a,
  output logic [SCORE_W-1:0] score_b,
  output logic [7:0]         round_cnt,
  output logic               match_done,
  output logic [1:0]         winner
);

  localparam logic [SCORE_W-1:0] WIN_SCORE = SCORE_W'(WIN_ROUNDS);

  if (WIN_ROUNDS < 1 || TIE_LIMIT < 1) begin : g_bad_params
    $error("rps_match_ctrl: WIN_ROUNDS and TIE_LIMIT must be >= 1");
  end

  state_e             state_q, state_d;
  logic [2:0]         move_a_q, move_a_d;
  logic [2:0]         move_b_q, move_b_d;
  logic               invalid_q, invalid_d;
  logic               result_valid_q, result_valid_d;
  result_e            round_result_q, round_result_d;
  logic [SCORE_W-1:0] score_a_q, score_a_d;
  logic [SCORE_W-1:0] score_b_q, score_b_d;
  logic [7:0]         round_cnt_q, round_cnt_d;
  winner_e            winner_q, winner_d;
  result_e            judge_res;

`ifdef RPS_TIE_LIMIT_EN
  localparam int              TIE_W   = $clog2(TIE_LIMIT + 1);
  localparam logic [TIE_W-1:0] TIE_MAX = TIE_W'(TIE_LIMIT);
  logic [TIE_W-1:0] tie_cnt_q, tie_cnt_d;
`endif

  rps_judge u_judge (
    .move_a (move_a_q),
    .move_b (move_b_q),
    .result (judge_res)
  );

  always_comb begin
    state_d        = state_q;
    move_a_d       = move_a_q;
    move_b_d       = move_b_q;
    invalid_d      = 1'b0;
    result_valid_d = 1'b0;
    round_result_d = round_result_q;
    score_a_d      = score_a_q;
    score_b_d      = score_b_q;
    round_cnt_d    = round_cnt_q;
    winner_d       = winner_q;
`ifdef RPS_TIE_LIMIT_EN
    tie_cnt_d      = tie_cnt_q;
`endif

    // A restart wins over anything else, including a round waiting in EVAL.
    if (new_match) begin
      state_d        = IDLE;
      round_result_d = NONE;
      score_a_d      = '0;
      score_b_d      = '0;
      round_cnt_d    = '0;
      winner_d       = WIN_NONE;
`ifdef RPS_TIE_LIMIT_EN
      tie_cnt_d      = '0;
`endif
    end else begin
      unique case (state_q)
        IDLE: begin
          if (submit && move_valid) begin
            move_a_d = move_a;
            move_b_d = move_b;
            state_d  = EVAL;
          end else if (submit) begin
            invalid_d = 1'b1;
          end
        end
        EVAL: begin
          result_valid_d = 1'b1;
          round_result_d = judge_res;
          round_cnt_d    = round_cnt_q + 8'd1;
          state_d        = IDLE;
          if (judge_res == A_WIN) score_a_d = score_a_q + SCORE_W'(1);
          if (judge_res == B_WIN) score_b_d = score_b_q + SCORE_W'(1);
          if (score_a_d == WIN_SCORE) begin
            state_d  = DONE;
            winner_d = WIN_A;
          end else if (score_b_d == WIN_SCORE) begin
            state_d  = DONE;
            winner_d = WIN_B;
          end
`ifdef RPS_TIE_LIMIT_EN
          if (judge_res == TIE) begin
            tie_cnt_d = tie_cnt_q + TIE_W'(1);
            if (tie_cnt_d == TIE_MAX) begin
              state_d  = DONE;
              winner_d = WIN_DRAW;
            end
          end else begin
            tie_cnt_d = '0;
          end
`endif
        end
        DONE: ;
        default: state_d = IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      move_a_q       <= '0;
      move_b_q       <= '0;
      invalid_q      <= 1'b0;
      result_valid_q <= 1'b0;
      round_result_q <= NONE;
      score_a_q      <= '0;
      score_b_q      <= '0;
      round_cnt_q    <= '0;
      winner_q       <= WIN_NONE;
    end else begin
      state_q        <= state_d;
      move_a_q       <= move_a_d;
      move_b_q       <= move_b_d;
      invalid_q      <= invalid_d;
      result_valid_q <= result_valid_d;
      round_result_q <= round_result_d;
      score_a_q      <= score_a_d;
      score_b_q      <= score_b_d;
      round_cnt_q    <= round_cnt_d;
      winner_q       <= winner_d;
    end
  end

`ifdef RPS_TIE_LIMIT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tie_cnt_q <= '0;
    else        tie_cnt_q <= tie_cnt_d;
  end
`endif

  assign invalid_pulse = invalid_q;
  assign result_valid  = result_valid_q;
  assign round_result  = round_result_q;
  assign score_a       = score_a_q;
  assign score_b       = score_b_q;
  assign round_cnt     = round_cnt_q;
  assign match_done    = (state_q == DONE);
  assign winner        = winner_q;

endmodule
